alu_op_fifo: RTL and testbench
==============================

Name: alu_op_fifo

Overview:
- Operand/opcode issue queue that sits directly upstream of the ALU top.
- Buffers {A, B, sel} requests from the producer and presents them in order with a valid/ready handshake on both sides.
- Absorbs ALU back-pressure and reports occupancy plus a saturating stall count for debug.

Parameters:
- WIDTH, 4: operand width in bits; must equal the ALU WIDTH.
- SEL_W, 2: opcode width in bits.
- DEPTH, 4: number of queue entries; power of two, minimum 2.
- AW, $clog2(DEPTH): pointer width; derived, do not override.
- STALL_W, 8: width of the stall counter.

Ports:
- i_CLK  in  1  clock; all logic is on the rising edge.
- i_RST  in  1  synchronous reset, active-high.
- i_A  in  WIDTH  producer operand A.
- i_B  in  WIDTH  producer operand B.
- i_sel  in  SEL_W  producer opcode.
- i_VALID  in  1  producer request valid.
- o_READY  out  1  queue can accept a request.
- o_A  out  WIDTH  head operand A, to the ALU.
- o_B  out  WIDTH  head operand B, to the ALU.
- o_sel  out  SEL_W  head opcode, to the ALU.
- o_VALID  out  1  head entry valid, to the ALU.
- i_READY  in  1  ALU accepts the head entry.
- o_count  out  AW+1  current occupancy, 0..DEPTH.
- o_full  out  1  o_count == DEPTH.
- o_empty  out  1  o_count == 0.
- o_stall_cnt  out  STALL_W  cycles with i_VALID=1 and o_READY=0; saturating.

Behaviour:
- Clock and reset: one clock, i_CLK. Reset i_RST is synchronous and active-high. All state is sampled on the rising edge of i_CLK.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, o_stall_cnt=0. Hence o_empty=1, o_full=0, o_VALID=0, o_A/o_B/o_sel=0. Storage contents are don't-care.
- o_READY is forced to 0 while i_RST=1, and equals !o_full otherwise.
- Reset mid-operation: all queued entries are discarded on the next edge. A push or pop presented in the reset cycle has no effect.
- Push: occurs when i_VALID & o_READY. Writes {i_A, i_B, i_sel} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: occurs when o_VALID & i_READY. rd_ptr increments modulo DEPTH.
- Show-ahead head: o_VALID = !o_empty. o_A/o_B/o_sel read the entry at rd_ptr combinationally from the registered storage and are 0 when empty.
- Latency: a push into an empty queue is visible at the head on the next cycle (1 cycle). There is no same-cycle bypass.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance.
- Full boundary: o_READY=0 even if a pop occurs in the same cycle. There is no write-through when full; the producer retries the next cycle.
- Empty boundary: i_READY is ignored; pointers and count are unchanged.
- Wrap-around: the pointers are AW bits and wrap naturally. Full/empty are derived from count, not from pointer compare.
- Hold rule: while o_VALID=1 and i_READY=0, o_A/o_B/o_sel/o_VALID must remain stable.
- Stall counter: increments when i_VALID=1 and o_READY=0 outside reset. It holds at 2^STALL_W-1 and clears only on reset.
- Opcodes pass through unchecked. Any SEL_W value is stored and forwarded verbatim.
- Producer contract: the producer must hold its payload stable while i_VALID=1 and o_READY=0. The queue does not latch unaccepted data.

Decomposition:
- Shared package alu_pkg:
  - SEL_W
  - opcode constants: OP_SUB=2'b00, OP_NAND=2'b01, OP_START_ONES=2'b10, OP_OH2U2=2'b11
  - packed request type alu_req_t {a, b, sel}, parameterised through WIDTH
- One sub-module, alu_op_fifo_mem:
  - DEPTH x (2*WIDTH+SEL_W) register array
  - synchronous write, combinational read
  - no reset on contents
- Pointer, count and handshake control stay in alu_op_fifo.

Test Plan:
1. Reset then idle: assert i_RST 2 cycles, release. Required: o_VALID=0, o_READY=1, o_count=0, o_empty=1, o_stall_cnt=0.
2. Single pass: push A=4'h3, B=4'h5, sel=OP_SUB with i_READY=1. Required: o_VALID rises 1 cycle later with o_A=3, o_B=5, o_sel=00 for exactly one cycle; o_count returns to 0.
3. Fill and back-pressure: i_READY=0, push 6 requests (A=1..6). Required: first 4 accepted; o_full=1 and o_READY=0 from the 4th push's next cycle; o_stall_cnt=2; head holds A=1 stable.
4. Drain with wrap: from the full state, raise i_READY. Required: o_A sequence 1,2,3,4 on consecutive cycles, then o_VALID=0. Push 3 more (A=7,8,9) while draining. Required: in-order output across the pointer wrap.
5. Simultaneous push/pop at count=2. Required: o_count stays 2 and output order is preserved. At full, pop plus i_VALID=1 still leaves o_READY=0 that cycle.
6. Reset mid-stream at count=3 with push and pop asserted. Required: next cycle o_count=0, o_VALID=0, o_stall_cnt=0, and no element is emitted after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its upstream operand/opcode queue.
//   ALU_WIDTH   : operand width of the ALU datapath
//   SEL_W       : opcode width
//   OP_*        : opcode encodings (the queue forwards them verbatim)
//   alu_req_t   : packed request {a, b, sel}, MSB-first in that order
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int SEL_W     = 2;

    localparam logic [SEL_W-1:0] OP_SUB       = 2'b00;
    localparam logic [SEL_W-1:0] OP_NAND      = 2'b01;
    localparam logic [SEL_W-1:0] OP_START_ONES = 2'b10;
    localparam logic [SEL_W-1:0] OP_OH2U2     = 2'b11;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
        logic [SEL_W-1:0]     sel;
    } alu_req_t;

endpackage

// File: rtl/alu_op_fifo_mem.sv
// ---------------------------------------------------------------------------
// alu_op_fifo_mem
// DEPTH x DW register array for the ALU issue queue.
//   clk     : rising-edge clock
//   wr_en   : write wr_data at wr_addr on the next rising edge
//   wr_addr : write index
//   wr_data : entry to store
//   rd_addr : read index
//   rd_data : entry at rd_addr, combinational read
// Contents are not reset; the controller masks them with its own count.
// ---------------------------------------------------------------------------
module alu_op_fifo_mem #(
    parameter int DW    = 10,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_op_fifo.sv
// ---------------------------------------------------------------------------
// alu_op_fifo
// In-order issue queue for {A, B, sel} requests in front of the ALU.
//   i_CLK, i_RST          : clock, synchronous active-high reset
//   i_A, i_B, i_sel       : producer payload
//   i_VALID / o_READY     : producer handshake
//   o_A, o_B, o_sel       : head entry (show-ahead, zero when empty)
//   o_VALID / i_READY     : ALU handshake
//   o_count               : occupancy 0..DEPTH
//   o_full, o_empty       : occupancy flags
//   o_stall_cnt           : saturating count of producer stall cycles
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds its payload while valid=1 and ready=0; this queue
// likewise holds its head stable while o_VALID=1 and i_READY=0.
// ---------------------------------------------------------------------------
module alu_op_fifo #(
    parameter  int WIDTH   = 4,
    parameter  int SEL_W   = alu_pkg::SEL_W,
    parameter  int DEPTH   = 4,
    parameter  int STALL_W = 8,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic [WIDTH-1:0]   i_A,
    input  logic [WIDTH-1:0]   i_B,
    input  logic [SEL_W-1:0]   i_sel,
    input  logic               i_VALID,
    output logic               o_READY,
    output logic [WIDTH-1:0]   o_A,
    output logic [WIDTH-1:0]   o_B,
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_VALID,
    input  logic               i_READY,
    output logic [AW:0]        o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic [STALL_W-1:0] o_stall_cnt
);

    import alu_pkg::*;

    localparam int          DW         = 2 * WIDTH + SEL_W;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [DW-1:0] rd_data;

    assign o_count = count;
    assign o_full  = (count == FULL_COUNT);
    assign o_empty = (count == '0);

    // Ready depends only on occupancy (and reset), never on i_READY, so a
    // pop in the full cycle does not open a write-through path.
    assign o_READY = !i_RST && !o_full;
    assign o_VALID = !o_empty;

    assign push = i_VALID && o_READY;
    assign pop  = o_VALID && i_READY;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_stall_cnt <= '0;
        end else if (i_VALID && !o_READY && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + STALL_W'(1);
        end
    end

    alu_op_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (i_CLK),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({i_A, i_B, i_sel}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Stale storage is never exposed: the head reads as zero when empty.
    assign {o_A, o_B, o_sel} = o_VALID ? rd_data : '0;

endmodule

// File: tb/tb_alu_op_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_op_fifo
// Directed vector table for reset / single pass / fill / drain, hand-written
// sequences for wrap, simultaneous push+pop, full boundary and mid-stream
// reset, and a negedge scoreboard that tracks the queue contents throughout.
// ---------------------------------------------------------------------------
module tb_alu_op_fifo;

    import alu_pkg::*;

    localparam int WIDTH   = 4;
    localparam int SEL_W   = 2;
    localparam int DEPTH   = 4;
    localparam int STALL_W = 8;
    localparam int AW      = $clog2(DEPTH);
    localparam int DW      = 2 * WIDTH + SEL_W;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst = 1'b1;
    logic               vld = 1'b0;
    logic               rdy = 1'b0;
    logic [WIDTH-1:0]   a   = '0;
    logic [WIDTH-1:0]   b   = '0;
    logic [SEL_W-1:0]   sel = '0;

    logic               dut_ready;
    logic [WIDTH-1:0]   dut_a;
    logic [WIDTH-1:0]   dut_b;
    logic [SEL_W-1:0]   dut_sel;
    logic               dut_valid;
    logic [AW:0]        dut_count;
    logic               dut_full;
    logic               dut_empty;
    logic [STALL_W-1:0] dut_stall;

    alu_op_fifo #(
        .WIDTH   (WIDTH),
        .SEL_W   (SEL_W),
        .DEPTH   (DEPTH),
        .STALL_W (STALL_W)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_A         (a),
        .i_B         (b),
        .i_sel       (sel),
        .i_VALID     (vld),
        .o_READY     (dut_ready),
        .o_A         (dut_a),
        .o_B         (dut_b),
        .o_sel       (dut_sel),
        .o_VALID     (dut_valid),
        .i_READY     (rdy),
        .o_count     (dut_count),
        .o_full      (dut_full),
        .o_empty     (dut_empty),
        .o_stall_cnt (dut_stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: model of queue contents, checked every negedge
    logic [DW-1:0] exp_q[$];
    int            m_stall = 0;
    logic          sb_en   = 1'b0;

    always @(negedge clk) begin
        logic m_push;
        logic m_pop;
        if (sb_en) begin
            chk("sb_valid", 32'(dut_valid), 32'(exp_q.size() != 0));
            chk("sb_count", 32'(dut_count), 32'(exp_q.size()));
            chk("sb_ready", 32'(dut_ready), 32'(!rst && exp_q.size() < DEPTH));
            chk("sb_stall", 32'(dut_stall), 32'(m_stall));
            if (exp_q.size() != 0) begin
                chk("sb_head", 32'({dut_a, dut_b, dut_sel}), 32'(exp_q[0]));
            end else begin
                chk("sb_head_zero", 32'({dut_a, dut_b, dut_sel}), 32'(0));
            end
        end
        // advance the model across the coming rising edge
        if (rst) begin
            exp_q.delete();
            m_stall = 0;
        end else begin
            m_push = vld && (exp_q.size() < DEPTH);
            m_pop  = rdy && (exp_q.size() > 0);
            if (vld && !m_push && m_stall < (2 ** STALL_W - 1)) m_stall++;
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) exp_q.push_back({a, b, sel});
        end
    end

    // driver tasks
    task automatic drive(input logic r, input logic v, input int av, input int bv,
                         input int sv, input logic rd);
        rst = r;
        vld = v;
        a   = WIDTH'(av);
        b   = WIDTH'(bv);
        sel = SEL_W'(sv);
        rdy = rd;
    endtask

    task automatic cyc(input logic r, input logic v, input int av, input int bv,
                       input int sv, input logic rd);
        drive(r, v, av, bv, sv, rd);
        @(posedge clk);
        #1;
    endtask

    // vector table
    typedef struct {
        logic               rst, vld;
        logic [WIDTH-1:0]   a, b;
        logic [SEL_W-1:0]   sel;
        logic               rdy;
        logic               e_valid, e_ready;
        logic [WIDTH-1:0]   e_a, e_b;
        logic [SEL_W-1:0]   e_sel;
        logic [AW:0]        e_count;
        logic               e_full, e_empty;
        logic [STALL_W-1:0] e_stall;
    } vec_t;

    function automatic vec_t mk(input int r, v, av, bv, sv, rd,
                                ev, er, ea, eb, es, ec, ef, ee, est);
        vec_t t;
        t.rst = r[0];      t.vld = v[0];
        t.a = WIDTH'(av);  t.b = WIDTH'(bv);  t.sel = SEL_W'(sv);
        t.rdy = rd[0];
        t.e_valid = ev[0]; t.e_ready = er[0];
        t.e_a = WIDTH'(ea); t.e_b = WIDTH'(eb); t.e_sel = SEL_W'(es);
        t.e_count = (AW + 1)'(ec);
        t.e_full = ef[0];  t.e_empty = ee[0];
        t.e_stall = STALL_W'(est);
        return t;
    endfunction

    localparam int NV = 17;
    vec_t vecs[NV];

    initial begin
        // expected values describe the outputs just after the row's edge
        //          rst vld a  b  sel rdy | val rdy a  b  sel cnt full emp stall
        vecs[0]  = mk(1, 0, 0, 0, 0,  0,    0,  0,  0, 0, 0,  0,  0,  1,  0);
        vecs[1]  = mk(1, 0, 0, 0, 0,  0,    0,  0,  0, 0, 0,  0,  0,  1,  0);
        vecs[2]  = mk(0, 0, 0, 0, 0,  0,    0,  1,  0, 0, 0,  0,  0,  1,  0);
        vecs[3]  = mk(0, 1, 3, 5, int'(OP_SUB), 1, 1, 1, 3, 5, 0, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0,  1,    0,  1,  0, 0, 0,  0,  0,  1,  0);
        vecs[5]  = mk(0, 0, 0, 0, 0,  0,    0,  1,  0, 0, 0,  0,  0,  1,  0);
        vecs[6]  = mk(0, 1, 1, 9, 1,  0,    1,  1,  1, 9, 1,  1,  0,  0,  0);
        vecs[7]  = mk(0, 1, 2, 10, 2, 0,    1,  1,  1, 9, 1,  2,  0,  0,  0);
        vecs[8]  = mk(0, 1, 3, 11, 3, 0,    1,  1,  1, 9, 1,  3,  0,  0,  0);
        vecs[9]  = mk(0, 1, 4, 12, 0, 0,    1,  0,  1, 9, 1,  4,  1,  0,  0);
        vecs[10] = mk(0, 1, 5, 13, 1, 0,    1,  0,  1, 9, 1,  4,  1,  0,  1);
        vecs[11] = mk(0, 1, 6, 14, 2, 0,    1,  0,  1, 9, 1,  4,  1,  0,  2);
        vecs[12] = mk(0, 0, 0, 0, 0,  0,    1,  0,  1, 9, 1,  4,  1,  0,  2);
        vecs[13] = mk(0, 0, 0, 0, 0,  1,    1,  1,  2, 10, 2, 3,  0,  0,  2);
        vecs[14] = mk(0, 0, 0, 0, 0,  1,    1,  1,  3, 11, 3, 2,  0,  0,  2);
        vecs[15] = mk(0, 0, 0, 0, 0,  1,    1,  1,  4, 12, 0, 1,  0,  0,  2);
        vecs[16] = mk(0, 0, 0, 0, 0,  1,    0,  1,  0, 0, 0,  0,  0,  1,  2);

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].rst, vecs[i].vld, int'(vecs[i].a), int'(vecs[i].b),
                int'(vecs[i].sel), vecs[i].rdy);
            sb_en = 1'b1;
            chk($sformatf("row%0d_valid", i), 32'(dut_valid), 32'(vecs[i].e_valid));
            chk($sformatf("row%0d_ready", i), 32'(dut_ready), 32'(vecs[i].e_ready));
            chk($sformatf("row%0d_head", i),  32'({dut_a, dut_b, dut_sel}),
                32'({vecs[i].e_a, vecs[i].e_b, vecs[i].e_sel}));
            chk($sformatf("row%0d_count", i), 32'(dut_count), 32'(vecs[i].e_count));
            chk($sformatf("row%0d_full", i),  32'(dut_full),  32'(vecs[i].e_full));
            chk($sformatf("row%0d_empty", i), 32'(dut_empty), 32'(vecs[i].e_empty));
            chk($sformatf("row%0d_stall", i), 32'(dut_stall), 32'(vecs[i].e_stall));
        end

        // push 7,8,9 while draining: pointers are past the wrap point here
        cyc(0, 1, 7, 8, 3, 1);
        chk("wrap_a7",  32'(dut_a), 32'(7));
        chk("wrap_c7",  32'(dut_count), 32'(1));
        cyc(0, 1, 8, 7, 0, 1);
        chk("wrap_a8",  32'(dut_a), 32'(8));
        chk("wrap_c8",  32'(dut_count), 32'(1));
        cyc(0, 1, 9, 6, 1, 1);
        chk("wrap_a9",  32'(dut_a), 32'(9));
        cyc(0, 0, 0, 0, 0, 1);
        chk("wrap_drained", 32'(dut_valid), 32'(0));

        // simultaneous push and pop at count=2
        cyc(0, 1, 10, 5, 2, 0);
        cyc(0, 1, 11, 4, 3, 0);
        chk("pp_fill_count", 32'(dut_count), 32'(2));
        cyc(0, 1, 12, 3, 0, 1);
        chk("pp_count_a", 32'(dut_count), 32'(2));
        chk("pp_head_a",  32'(dut_a), 32'(11));
        cyc(0, 1, 13, 2, 1, 1);
        chk("pp_count_b", 32'(dut_count), 32'(2));
        chk("pp_head_b",  32'(dut_a), 32'(12));
        cyc(0, 1, 14, 1, 2, 0);
        cyc(0, 1, 15, 0, 3, 0);
        chk("pp_full", 32'(dut_full), 32'(1));

        // full with pop and valid together: no write-through this cycle
        drive(0, 1, 1, 1, 1, 1);
        #1;
        chk("full_pop_ready", 32'(dut_ready), 32'(0));
        @(posedge clk);
        #1;
        chk("full_pop_count", 32'(dut_count), 32'(3));
        chk("full_pop_head",  32'(dut_a), 32'(13));
        chk("full_pop_stall", 32'(dut_stall), 32'(3));

        // reset mid-stream at count=3 with push and pop asserted
        cyc(1, 1, 2, 2, 2, 1);
        chk("rst_count", 32'(dut_count), 32'(0));
        chk("rst_valid", 32'(dut_valid), 32'(0));
        chk("rst_stall", 32'(dut_stall), 32'(0));
        chk("rst_ready", 32'(dut_ready), 32'(0));
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 1);
            chk($sformatf("post_rst_valid%0d", k), 32'(dut_valid), 32'(0));
            chk($sformatf("post_rst_ready%0d", k), 32'(dut_ready), 32'(1));
        end

        // short random tail, scoreboard only; producer holds payload while stalled
        for (int k = 0; k < 40; k++) begin
            if (!(vld && !dut_ready)) begin
                drive(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < DEPTH + 1; k++) cyc(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        chk("final_drained", 32'(exp_q.size()), 32'(0));
        chk("final_empty", 32'(dut_empty), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
